// File: rtl/game2048_pkg.sv
// Shared constants and types for the 2048 game controller.
// Tiles are 4-bit exponents; the board is 16 tiles, row-major.
package game2048_pkg;

  localparam int TILE_W  = 4;
  localparam int BOARD_W = 64;

  localparam logic [3:0] DEF_WIN_EXP = 4'd11;
  localparam logic [3:0] EXP_MAX     = 4'd15;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LINE   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_SPAWN  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_END    = 3'd5;
  localparam logic [2:0] S_CLEAR  = 3'd6;

  localparam int D_UP    = 3;
  localparam int D_DOWN  = 2;
  localparam int D_LEFT  = 1;
  localparam int D_RIGHT = 0;

  localparam logic [1:0] ES_PLAY = 2'b00;
  localparam logic [1:0] ES_WIN  = 2'b01;
  localparam logic [1:0] ES_LOSE = 2'b10;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [3:0] line_t;

  // Board cell visited at position pos of line ln.
  // Left is the fall-through ordering.
  function automatic logic [3:0] cell_idx(
    input logic [3:0] dir,
    input logic [1:0] ln,
    input logic [1:0] pos
  );
    logic [1:0] rpos;
    rpos = 2'd3 - pos;
    cell_idx = {ln, pos};
    case (1'b1)
      dir[D_RIGHT]: cell_idx = {ln, rpos};
      dir[D_UP]:    cell_idx = {pos, ln};
      dir[D_DOWN]:  cell_idx = {rpos, ln};
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/move_sequencer_line_merge.sv
// Combinational slide-and-merge of one 4-tile line toward index 0.
// Each pair merges at most once; merges never chain.
module line_merge
  import game2048_pkg::*;
(
  input  line_t line_in,
  output line_t line_out,
  output logic  changed
);

  line_t c;

  function automatic tile_t inc(input tile_t t);
    return (t == EXP_MAX) ? EXP_MAX : t + 4'd1;
  endfunction

  // Compact non-empty tiles, then merge equal neighbours once.
  always_comb begin
    int k;
    c = '0;
    k = 0;
    for (int j = 0; j < 4; j++) begin
      if (line_in[j] != '0) begin
        c[k[1:0]] = line_in[j];
        k = k + 1;
      end
    end
    line_out = '0;
    if (c[0] != '0 && c[0] == c[1]) begin
      line_out[0] = inc(c[0]);
      if (c[2] != '0 && c[2] == c[3]) begin
        line_out[1] = inc(c[2]);
      end else begin
        line_out[1] = c[2];
        line_out[2] = c[3];
      end
    end else begin
      line_out[0] = c[0];
      if (c[1] != '0 && c[1] == c[2]) begin
        line_out[1] = inc(c[1]);
        line_out[2] = c[3];
      end else begin
        line_out[1] = c[1];
        if (c[2] != '0 && c[2] == c[3]) begin
          line_out[2] = inc(c[2]);
        end else begin
          line_out[2] = c[2];
          line_out[3] = c[3];
        end
      end
    end
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/move_sequencer.sv
// Sequences one 2048 move: four line merges, commit, spawn, check.
// Drives the box write strobe and the game end status.
module move_sequencer
  import game2048_pkg::*;
#(
  parameter logic [3:0]  WIN_EXP   = DEF_WIN_EXP,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         direction,
  input  logic [BOARD_W-1:0] oldvalues,
  output logic               enable,
  output logic [BOARD_W-1:0] newvalues,
  output logic [1:0]         endstatus,
  output logic               busy,
  output logic [2:0]         state
);

  logic [2:0]  state_q;
  logic [1:0]  line_q;
  logic [3:0]  dir_q;
  logic        changed_q;
  logic [1:0]  spawn_q;
  logic [1:0]  es_q;
  logic [15:0] lfsr_q;
  tile_t       work_q [16];
  tile_t       cur [16];

  line_t       mline;
  line_t       lm_out;
  logic        lm_chg;
  logic        dir_ok;
  logic        sp_ok;
  logic [3:0]  sp_idx;
  tile_t       sp_val;
  logic        win;
  logic        empty;
  logic        pair;

  assign state     = state_q;
  assign endstatus = es_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_END);
  assign dir_ok    = (direction != '0) &&
                     ((direction & (direction - 4'd1)) == '0);
  assign sp_val    = (lfsr_q[15:13] == 3'b111) ? 4'd2 : 4'd1;

  line_merge u_merge (
    .line_in  (mline),
    .line_out (lm_out),
    .changed  (lm_chg)
  );

  // Unpack the live board and gather the current line from work.
  always_comb begin
    mline = '0;
    for (int i = 0; i < 16; i++) begin
      cur[i] = oldvalues[63-4*i -: 4];
    end
    for (int j = 0; j < 4; j++) begin
      mline[j] = work_q[cell_idx(dir_q, line_q, 2'(j))];
    end
  end

  // First empty cell at or after lfsr[3:0], wrapping.
  always_comb begin
    logic [3:0] idx;
    idx    = '0;
    sp_ok  = 1'b0;
    sp_idx = '0;
    for (int k = 15; k >= 0; k--) begin
      idx = lfsr_q[3:0] + 4'(k);
      if (cur[idx] == '0) begin
        sp_ok  = 1'b1;
        sp_idx = idx;
      end
    end
  end

  // Win tile, empty cell and mergeable neighbour detection.
  always_comb begin
    win   = 1'b0;
    empty = 1'b0;
    pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cur[i] >= WIN_EXP) win = 1'b1;
      if (cur[i] == '0) empty = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cur[4*r+c] == cur[4*r+c+1]) pair = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (cur[i] == cur[i+4]) pair = 1'b1;
    end
  end

  // Box write strobe and the board presented to the boxes.
  always_comb begin
    enable    = 1'b0;
    newvalues = oldvalues;
    case (state_q)
      S_CLEAR: begin
        enable    = 1'b1;
        newvalues = '0;
      end
      S_COMMIT: begin
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
          newvalues[63-4*i -: 4] = work_q[i];
        end
      end
      S_SPAWN: begin
        if (sp_ok) begin
          enable = 1'b1;
          newvalues[63-4*int'(sp_idx) -: 4] = sp_val;
        end
      end
      default: ;
    endcase
  end

  // Free-running Galois LFSR, taps 16,14,13,11.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^
                (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Move sequencing FSM; start overrides everything but reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      dir_q     <= '0;
      changed_q <= 1'b0;
      spawn_q   <= '0;
      es_q      <= ES_PLAY;
      for (int i = 0; i < 16; i++) work_q[i] <= '0;
    end else if (start) begin
      state_q <= S_CLEAR;
      es_q    <= ES_PLAY;
      spawn_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dir_ok) begin
            dir_q     <= direction;
            line_q    <= '0;
            changed_q <= 1'b0;
            state_q   <= S_LINE;
            for (int i = 0; i < 16; i++) work_q[i] <= cur[i];
          end
        end
        S_LINE: begin
          for (int j = 0; j < 4; j++) begin
            work_q[cell_idx(dir_q, line_q, 2'(j))] <= lm_out[j];
          end
          changed_q <= changed_q | lm_chg;
          line_q    <= line_q + 2'd1;
          if (line_q == 2'd3) begin
            state_q <= (changed_q | lm_chg) ? S_COMMIT : S_IDLE;
          end
        end
        S_COMMIT: state_q <= S_SPAWN;
        S_SPAWN: begin
          if (spawn_q == 2'd0) begin
            state_q <= S_CHECK;
          end else if (spawn_q == 2'd2) begin
            spawn_q <= 2'd1;
          end else begin
            spawn_q <= 2'd0;
            state_q <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (win) begin
            es_q    <= ES_WIN;
            state_q <= S_END;
          end else if (!empty && !pair) begin
            es_q    <= ES_LOSE;
            state_q <= S_END;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_END: ;
        S_CLEAR: begin
          state_q <= S_SPAWN;
          spawn_q <= 2'd2;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
